bayer_mosaic: RTL

BAYER_MOSAIC -- requirements
Module: bayer_mosaic

---
 rtl/bayer_mosaic_if.sv | 28 ++
 rtl/bayer_mosaic.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bayer_mosaic_if.sv
// Pixel bus for bayer_mosaic: RGB video in, Bayer mosaic samples and line/frame stats out.
interface bayer_mosaic_if #(
  parameter int unsigned DATA_WIDTH = 10
);
  localparam int unsigned CNT_W = 12;

  logic                  vsync_i;
  logic                  de_i;
  logic [DATA_WIDTH-1:0] data_r_i;
  logic [DATA_WIDTH-1:0] data_g_i;
  logic [DATA_WIDTH-1:0] data_b_i;
  logic                  de_o;
  logic                  vsync_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CNT_W-1:0]      line_length_o;
  logic [CNT_W-1:0]      frame_lines_o;
  logic                  length_err_o;

  modport master (
    output vsync_i, de_i, data_r_i, data_g_i, data_b_i,
    input  de_o, vsync_o, data_o, line_length_o, frame_lines_o, length_err_o
  );

  modport slave (
    input  vsync_i, de_i, data_r_i, data_g_i, data_b_i,
    output de_o, vsync_o, data_o, line_length_o, frame_lines_o, length_err_o
  );
endinterface

// File: rtl/bayer_mosaic.sv
// Converts an RGB pixel stream to a single-channel Bayer mosaic, with line length
// and frame line-count monitoring.
module bayer_mosaic #(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned PATTERN         = 0,
  parameter int unsigned MAX_DATA_LENGTH = 640
) (
  input logic             clk,
  input logic             reset,
  bayer_mosaic_if.slave   pix_if
);

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LINE_REF = CNT_W'(MAX_DATA_LENGTH);
  localparam logic [1:0]       R_POS    = 2'(PATTERN);
  localparam logic [1:0]       B_POS    = R_POS ^ 2'b11;

  logic                  vs_q, vs_d;
  logic                  de_q, de_d;
  logic                  col_q, col_d;
  logic                  row_q, row_d;
  logic [CNT_W-1:0]      pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0]      line_len_q, line_len_d;
  logic [CNT_W-1:0]      frame_lines_q, frame_lines_d;
  logic                  err_q, err_d;
  logic                  de_out_q, de_out_d;
  logic                  vs_out_q, vs_out_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  de_rise, de_fall, vs_rise;
  logic                  col_cur;
  logic [1:0]            site;
  logic [DATA_WIDTH-1:0] sel;
  logic [CNT_W-1:0]      lines_plus;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Edge detection against the registered input copies
  always_comb begin
    de_rise = pix_if.de_i & ~de_q;
    de_fall = ~pix_if.de_i & de_q;
    vs_rise = pix_if.vsync_i & ~vs_q;
  end

  // Colour site of the current pixel; R and B sit on opposite corners of the 2x2 tile
  always_comb begin
    col_cur    = de_rise ? 1'b0 : ~col_q;
    site       = {row_q, col_cur};
    lines_plus = sat_inc(line_cnt_q);
    if (site == R_POS) begin
      sel = pix_if.data_r_i;
    end else if (site == B_POS) begin
      sel = pix_if.data_b_i;
    end else begin
      sel = pix_if.data_g_i;
    end
  end

  // Next-state logic
  always_comb begin
    vs_d          = pix_if.vsync_i;
    de_d          = pix_if.de_i;
    col_d         = col_q;
    row_d         = row_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    err_d         = err_q;
    de_out_d      = pix_if.de_i;
    vs_out_d      = pix_if.vsync_i;
    data_d        = '0;

    if (pix_if.de_i) begin
      col_d     = col_cur;
      pix_cnt_d = sat_inc(pix_cnt_q);
      data_d    = sel;
    end

    if (de_fall) begin
      line_len_d = pix_cnt_q;
      pix_cnt_d  = '0;
      line_cnt_d = lines_plus;
    end

    // Frame boundary takes priority over a row toggle; the line ending now still counts
    if (vs_rise) begin
      row_d         = 1'b0;
      frame_lines_d = de_fall ? lines_plus : line_cnt_q;
      line_cnt_d    = '0;
      err_d         = 1'b0;
    end else if (de_fall) begin
      row_d = ~row_q;
    end

    if (de_fall && (pix_cnt_q != LINE_REF)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      col_q         <= 1'b0;
      row_q         <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= 1'b0;
      de_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      data_q        <= '0;
    end else begin
      vs_q          <= vs_d;
      de_q          <= de_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      de_out_q      <= de_out_d;
      vs_out_q      <= vs_out_d;
      data_q        <= data_d;
    end
  end

  assign pix_if.de_o          = de_out_q;
  assign pix_if.vsync_o       = vs_out_q;
  assign pix_if.data_o        = data_q;
  assign pix_if.line_length_o = line_len_q;
  assign pix_if.frame_lines_o = frame_lines_q;
  assign pix_if.length_err_o  = err_q;

endmodule
